peak_note_detector: RTL and testbench



---
 rtl/peak_note_pkg.sv | 22 ++
 rtl/peak_note_detector_if.sv | 14 +
 rtl/peak_note_detector_bin_to_note.sv | 19 +
 rtl/peak_note_detector.sv | 117 +++++++++++
 tb/tb_peak_note_detector.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/peak_note_pkg.sv
// Shared types and note lookup table for the peak note detector.
// NOTE_BOUND holds the lowest FFT bin of each equal-temperament note (ascending).
package peak_note_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, EVAL, DONE} state_t;

    localparam int NOTE_W     = 6;
    localparam int BOUND_W    = 11;
    localparam int NUM_BOUNDS = 63;

    localparam logic [BOUND_W-1:0] NOTE_BOUND [NUM_BOUNDS] = '{
        11'd2,   11'd3,   11'd4,   11'd5,   11'd6,   11'd7,   11'd8,   11'd9,
        11'd10,  11'd11,  11'd12,  11'd13,  11'd14,  11'd15,  11'd16,  11'd17,
        11'd18,  11'd19,  11'd20,  11'd21,  11'd22,  11'd24,  11'd25,  11'd27,
        11'd28,  11'd30,  11'd32,  11'd34,  11'd36,  11'd38,  11'd40,  11'd42,
        11'd45,  11'd48,  11'd50,  11'd53,  11'd57,  11'd60,  11'd64,  11'd67,
        11'd71,  11'd76,  11'd80,  11'd85,  11'd90,  11'd95,  11'd101, 11'd107,
        11'd113, 11'd120, 11'd127, 11'd135, 11'd143, 11'd151, 11'd160, 11'd170,
        11'd180, 11'd190, 11'd202, 11'd214, 11'd227, 11'd240, 11'd254
    };

endpackage

// File: rtl/peak_note_detector_if.sv
// Magnitude stream from the filter plus the frame-done handshake back to it.
interface peak_note_detector_if #(
    parameter int MAG_W = 64,
    parameter int IDX_W = 11
);
    logic             start;
    logic             mag_valid;
    logic [MAG_W-1:0] mag;
    logic [IDX_W-1:0] index;
    logic             done;

    modport master (output start, mag_valid, mag, index, input done);
    modport slave  (input start, mag_valid, mag, index, output done);
endinterface

// File: rtl/peak_note_detector_bin_to_note.sv
// Combinational bin-to-note mapping: number of note boundaries at or below the bin.
module bin_to_note
    import peak_note_pkg::*;
#(
    parameter int IDX_W = 11
) (
    input  logic [IDX_W-1:0]  bin,
    output logic [NOTE_W-1:0] note_num
);

    always_comb begin
        note_num = '0;
        for (int i = 0; i < NUM_BOUNDS; i++) begin
            if (int'(bin) >= int'(NOTE_BOUND[i]))
                note_num = note_num + NOTE_W'(1);
        end
    end

endmodule

// File: rtl/peak_note_detector.sv
// Per-frame peak search over the magnitude stream with multi-frame debounce
// before the peak bin and its note number are published.
module peak_note_detector
    import peak_note_pkg::*;
#(
    parameter int               MAG_W         = 64,
    parameter int               IDX_W         = 11,
    parameter int               NUM_BINS      = 1024,
    parameter int               MIN_BIN       = 2,
    parameter logic [MAG_W-1:0] THRESH        = 64'd1000000,
    parameter int               STABLE_FRAMES = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    peak_note_detector_if.slave  bus,
    output logic [IDX_W-1:0]     peak_index,
    output logic [MAG_W-1:0]     peak_mag,
    output logic [NOTE_W-1:0]    note_num,
    output logic                 note_valid
);

    localparam int              CNT_W   = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES);

    state_t              state;
    logic                done_r;
    logic [MAG_W-1:0]    max_mag;
    logic [IDX_W-1:0]    max_idx;
    logic [IDX_W:0]      cand;
    logic [IDX_W:0]      new_cand;
    logic [CNT_W-1:0]    stable_cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                bin_wins;
    logic                last_bin;
    logic [NOTE_W-1:0]   max_note;

    assign bus.done = done_r;

    bin_to_note #(.IDX_W(IDX_W)) u_bin_to_note (
        .bin      (max_idx),
        .note_num (max_note)
    );

    // Candidate is {valid, bin}; an empty frame is all-zero so repeated silence also debounces.
    always_comb begin
        bin_wins = bus.mag_valid && (int'(bus.index) >= MIN_BIN) &&
                   (int'(bus.index) < NUM_BINS) && (bus.mag > max_mag);
        last_bin = bus.mag_valid && (int'(bus.index) == NUM_BINS - 1);
        new_cand = (max_mag >= THRESH) ? {1'b1, max_idx} : '0;
        if (new_cand != cand)
            cnt_next = CNT_W'(1);
        else if (stable_cnt == CNT_MAX)
            cnt_next = CNT_MAX;
        else
            cnt_next = stable_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            done_r     <= 1'b0;
            max_mag    <= '0;
            max_idx    <= '0;
            cand       <= '0;
            stable_cnt <= '0;
            peak_index <= '0;
            peak_mag   <= '0;
            note_num   <= '0;
            note_valid <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        max_mag <= '0;
                        max_idx <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    // A restart drops whatever bin arrives alongside it.
                    if (bus.start) begin
                        max_mag <= '0;
                        max_idx <= '0;
                    end else begin
                        if (bin_wins) begin
                            max_mag <= bus.mag;
                            max_idx <= bus.index;
                        end
                        if (last_bin)
                            state <= EVAL;
                    end
                end
                EVAL: begin
                    cand       <= new_cand;
                    stable_cnt <= cnt_next;
                    if (cnt_next == CNT_MAX) begin
                        if (new_cand[IDX_W]) begin
                            peak_index <= max_idx;
                            peak_mag   <= max_mag;
                            note_num   <= max_note;
                            note_valid <= 1'b1;
                        end else begin
                            note_num   <= '0;
                            note_valid <= 1'b0;
                        end
                    end
                    done_r <= 1'b1;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peak_note_detector.sv
// Directed frame sequence with randomized background, stalls and peaks,
// checked against a frame-level reference model.
module tb_peak_note_detector;
    import peak_note_pkg::*;

    localparam int          MAG_W    = 64;
    localparam int          IDX_W    = 11;
    localparam int          NUM_BINS = 1024;
    localparam int          MIN_BIN  = 2;
    localparam int          STABLE   = 3;
    localparam logic [63:0] THRESH   = 64'd1000000;

    logic             CLOCK_50 = 1'b0;
    logic             reset;
    logic [IDX_W-1:0] peak_index;
    logic [MAG_W-1:0] peak_mag;
    logic [5:0]       note_num;
    logic             note_valid;

    int total = 0;
    int bad   = 0;

    logic [63:0]      fm [NUM_BINS];
    logic [IDX_W:0]   hist [$];
    logic [IDX_W-1:0] exp_idx;
    logic [63:0]      exp_mag;
    logic [5:0]       exp_note;
    logic             exp_valid;

    peak_note_detector_if #(.MAG_W(MAG_W), .IDX_W(IDX_W)) bus ();

    peak_note_detector #(
        .MAG_W(MAG_W), .IDX_W(IDX_W), .NUM_BINS(NUM_BINS), .MIN_BIN(MIN_BIN),
        .THRESH(THRESH), .STABLE_FRAMES(STABLE)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .bus        (bus),
        .peak_index (peak_index),
        .peak_mag   (peak_mag),
        .note_num   (note_num),
        .note_valid (note_valid)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [5:0] ref_note(input int b);
        int n = 0;
        for (int k = 0; k < NUM_BOUNDS; k++)
            if (b >= int'(NOTE_BOUND[k])) n++;
        return 6'(n);
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_reset();
        hist.delete();
        exp_idx = '0; exp_mag = '0; exp_note = '0; exp_valid = 1'b0;
    endtask

    // Frame result: first strongest in-range bin, published once the last STABLE results agree.
    task automatic model_frame();
        logic [63:0]    bm;
        int             bi;
        logic [IDX_W:0] c;
        bit             same;
        bm = '0; bi = 0;
        for (int i = MIN_BIN; i < NUM_BINS; i++)
            if (fm[i] > bm) begin bm = fm[i]; bi = i; end
        c = (bm >= THRESH) ? {1'b1, IDX_W'(bi)} : '0;
        hist.push_back(c);
        if (hist.size() > STABLE) void'(hist.pop_front());
        same = (hist.size() == STABLE);
        for (int k = 1; k < hist.size(); k++)
            if (hist[k] != hist[0]) same = 1'b0;
        if (same) begin
            if (c[IDX_W]) begin
                exp_idx = IDX_W'(bi); exp_mag = bm; exp_note = ref_note(bi); exp_valid = 1'b1;
            end else begin
                exp_note = '0; exp_valid = 1'b0;
            end
        end
    endtask

    task automatic make_frame(input int idx, input logic [63:0] m);
        for (int i = 0; i < NUM_BINS; i++) fm[i] = 64'($urandom_range(0, 1000));
        fm[idx] = m;
    endtask

    task automatic drive_bin(input int i, input logic [63:0] m);
        bus.mag_valid = 1'b1;
        bus.index     = IDX_W'(i);
        bus.mag       = m;
        tick();
    endtask

    task automatic maybe_stall();
        if ($urandom_range(0, 15) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.mag_valid = 1'b1;
                bus.index     = IDX_W'($urandom_range(NUM_BINS, 2047));
            end else begin
                bus.mag_valid = 1'b0;
                bus.index     = IDX_W'($urandom_range(0, 2047));
            end
            bus.mag = 64'hFFFF_FFFF_FFFF_FFFF;
            tick();
        end
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        bus.mag_valid = 1'b0;
        tick();
        bus.start = 1'b0;
    endtask

    // restart_at >= 0 sends a decoy partial frame, then restarts with a colliding bin.
    task automatic send_frame(input int restart_at);
        bit got;
        start_frame();
        if (restart_at >= 0) begin
            for (int i = 0; i < restart_at; i++)
                drive_bin(i, (i == 50) ? 64'd8000000 : 64'd500);
            bus.start = 1'b1;
            drive_bin(restart_at, 64'd9000000000);
            bus.start = 1'b0;
        end
        for (int i = 0; i < NUM_BINS; i++) begin
            maybe_stall();
            drive_bin(i, fm[i]);
        end
        bus.mag_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.done) begin got = 1'b1; break; end
        end
        chk("done_pulse", 64'(got), 64'd1);
        model_frame();
        chk("peak_index", 64'(peak_index), 64'(exp_idx));
        chk("peak_mag",   peak_mag,        exp_mag);
        chk("note_num",   64'(note_num),   64'(exp_note));
        chk("note_valid", 64'(note_valid), 64'(exp_valid));
        if (got) begin
            tick();
            chk("done_one_cycle", 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        bit seen;
        reset = 1'b1;
        bus.start = 1'b0; bus.mag_valid = 1'b0; bus.index = '0; bus.mag = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_done",       64'(bus.done),   64'd0);
        chk("rst_peak_index", 64'(peak_index), 64'd0);
        chk("rst_peak_mag",   peak_mag,        64'd0);
        chk("rst_note_num",   64'(note_num),   64'd0);
        chk("rst_note_valid", 64'(note_valid), 64'd0);
        reset = 1'b0;
        tick();

        // Establish bin 100, then reset in the middle of a frame.
        for (int f = 0; f < 3; f++) begin make_frame(100, 64'd5000000); send_frame(-1); end
        chk("est_idx",   64'(peak_index), 64'd100);
        chk("est_mag",   peak_mag,        64'd5000000);
        chk("est_valid", 64'(note_valid), 64'd1);
        chk("est_note",  64'(note_num),   64'(ref_note(100)));

        make_frame(100, 64'd5000000);
        start_frame();
        for (int i = 0; i < 500; i++) drive_bin(i, fm[i]);
        reset = 1'b1;
        bus.mag_valid = 1'b0;
        tick();
        chk("mid_rst_peak_index", 64'(peak_index), 64'd0);
        chk("mid_rst_peak_mag",   peak_mag,        64'd0);
        chk("mid_rst_note_num",   64'(note_num),   64'd0);
        chk("mid_rst_note_valid", 64'(note_valid), 64'd0);
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 500; i < NUM_BINS; i++) begin
            drive_bin(i, 64'd9000000000);
            if (bus.done) seen = 1'b1;
        end
        bus.mag_valid = 1'b0;
        repeat (4) begin tick(); if (bus.done) seen = 1'b1; end
        chk("idle_ignores_bins", 64'(seen), 64'd0);
        for (int f = 0; f < 3; f++) begin make_frame(100, 64'd5000000); send_frame(-1); end
        chk("post_rst_idx", 64'(peak_index), 64'd100);

        // Ties keep the lower bin; bins below MIN_BIN never win.
        for (int f = 0; f < 3; f++) begin
            make_frame(40, 64'd2000000);
            fm[60] = 64'd2000000;
            fm[1]  = 64'd9000000000;
            send_frame(-1);
        end
        chk("tie_idx", 64'(peak_index), 64'd40);

        // Debounce: only three consecutive 200 frames move the output.
        for (int f = 0; f < 3; f++) begin make_frame(100, 64'd5000000); send_frame(-1); end
        for (int f = 0; f < 6; f++) begin
            if (f == 2) make_frame(100, 64'd5000000);
            else        make_frame(200, 64'd6000000);
            send_frame(-1);
            if (f == 4) chk("debounce_hold", 64'(peak_index), 64'd100);
        end
        chk("debounce_move", 64'(peak_index), 64'd200);

        // Threshold: just below drops the note, exactly at counts as valid.
        for (int f = 0; f < 3; f++) begin make_frame(100, 64'd5000000); send_frame(-1); end
        for (int f = 0; f < 3; f++) begin make_frame(300, 64'd999999); send_frame(-1); end
        chk("below_thr_valid", 64'(note_valid), 64'd0);
        chk("below_thr_note",  64'(note_num),   64'd0);
        chk("below_thr_idx",   64'(peak_index), 64'd100);
        for (int f = 0; f < 3; f++) begin make_frame(100, 64'd1000000); send_frame(-1); end
        chk("at_thr_valid", 64'(note_valid), 64'd1);

        // Restart mid-scan discards the decoy peak and the colliding bin.
        for (int f = 0; f < 3; f++) begin make_frame(500, 64'd3000000); send_frame(300); end
        chk("restart_idx", 64'(peak_index), 64'd500);
        chk("restart_mag", peak_mag,        64'd3000000);

        // Random peaks straddling the threshold.
        for (int f = 0; f < 5; f++) begin
            make_frame(($urandom_range(0, 1) == 1) ? 150 : 700,
                       64'd999000 + 64'($urandom_range(0, 2000)));
            if ($urandom_range(0, 1) == 1) fm[0] = 64'd7000000000;
            send_frame(-1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
